// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity bit, stop bit.
// One bit per clk. All outputs are registered. Requests are taken only in IDLE; requests seen while busy are dropped.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  par_en_in,
  input  logic                  par_type_in,
  input  logic                  par_bit_in,
  output logic [DATA_WIDTH-1:0] par_data_out,
  output logic                  par_type_out,
  output logic                  par_data_valid_out,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic [DATA_WIDTH-1:0] par_data_d;
  logic                  par_type_d, par_vld_d;
  logic                  tx_d, busy_d, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      shift_q            <= '0;
      cnt_q              <= '0;
      par_en_q           <= 1'b0;
      par_data_out       <= '0;
      par_type_out       <= 1'b0;
      par_data_valid_out <= 1'b0;
      tx_out             <= 1'b1;
      busy_out           <= 1'b0;
      done_out           <= 1'b0;
    end else begin
      state_q            <= state_d;
      shift_q            <= shift_d;
      cnt_q              <= cnt_d;
      par_en_q           <= par_en_d;
      par_data_out       <= par_data_d;
      par_type_out       <= par_type_d;
      par_data_valid_out <= par_vld_d;
      tx_out             <= tx_d;
      busy_out           <= busy_d;
      done_out           <= done_d;
    end
  end

  // Each branch computes the outputs for the state being entered, so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    par_en_d   = par_en_q;
    par_data_d = par_data_out;
    par_type_d = par_type_out;
    par_vld_d  = 1'b0;
    tx_d       = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_valid_in) begin
          shift_d    = data_in;
          par_data_d = data_in;
          par_type_d = par_type_in;
          par_en_d   = par_en_in;
          par_vld_d  = 1'b1;
          state_d    = START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        busy_d  = 1'b1;
      end
      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_in;
          end else begin
            state_d = STOP;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: begin
        state_d = STOP;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboarded bench for uart_tx_ctrl: the reference model pushes expected frames and strobes,
// and a negedge monitor assembles the serial frames and compares them against those expectations.
module tb_uart_tx_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_valid_in = 1'b0;
  logic         par_en_in = 1'b0;
  logic         par_type_in = 1'b0;
  logic         par_bit_in;
  logic [W-1:0] par_data_out;
  logic         par_type_out;
  logic         par_data_valid_out;
  logic         tx_out;
  logic         busy_out;
  logic         done_out;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
    .par_en_in(par_en_in), .par_type_in(par_type_in), .par_bit_in(par_bit_in),
    .par_data_out(par_data_out), .par_type_out(par_type_out),
    .par_data_valid_out(par_data_valid_out), .tx_out(tx_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  // Stand-in for the external parity calculator: result registered one cycle after the strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) par_bit_in <= 1'b0;
    else if (par_data_valid_out) par_bit_in <= (^par_data_out) ^ par_type_out;
  end

  typedef struct { logic [15:0] bits; int len; int start; } frame_t;
  typedef struct { logic [W-1:0] d; logic t; } strobe_t;

  frame_t  frame_q[$];
  strobe_t strobe_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cool = 0;
  bit in_frame = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is accepted when the line has been idle long enough.
  // The frame is then fully determined by the word and the configuration latched at acceptance.
  always @(posedge clk) begin
    frame_t  f;
    strobe_t s;
    cyc++;
    if (reset) cool = 0;
    else if (cool > 0) cool--;
    else if (data_valid_in) begin
      f.bits = '0;
      for (int i = 0; i < W; i++) f.bits[1+i] = data_in[i];
      if (par_en_in) begin
        f.bits[W+1] = ($countones(data_in) % 2 == 1) ^ par_type_in;
        f.bits[W+2] = 1'b1;
        f.len = W + 3;
      end else begin
        f.bits[W+1] = 1'b1;
        f.len = W + 2;
      end
      f.start = cyc;
      frame_q.push_back(f);
      s.d = data_in;
      s.t = par_type_in;
      strobe_q.push_back(s);
      cool = f.len;
    end
  end

  // Monitor
  logic [15:0]  got;
  int           nbits, start_cyc, done_at, ndone;
  logic [W-1:0] last_pd = '0;
  logic         last_pt = 1'b0;

  always @(negedge clk) begin
    frame_t  e;
    strobe_t s;
    logic [15:0] mask;
    if (reset) begin
      in_frame = 0;
      last_pd = '0;
      last_pt = 1'b0;
      chk("rst_tx", int'(tx_out), 1);
      chk("rst_busy", int'(busy_out), 0);
      chk("rst_done", int'(done_out), 0);
      chk("rst_strobe", int'(par_data_valid_out), 0);
      chk("rst_pdata", int'(par_data_out), 0);
      chk("rst_ptype", int'(par_type_out), 0);
    end else begin
      if (par_data_valid_out) begin
        if (strobe_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          s = strobe_q.pop_front();
          chk("strobe_pdata", int'(par_data_out), int'(s.d));
          chk("strobe_ptype", int'(par_type_out), int'(s.t));
          last_pd = s.d;
          last_pt = s.t;
        end
      end else begin
        chk("hold_pdata", int'(par_data_out), int'(last_pd));
        chk("hold_ptype", int'(par_type_out), int'(last_pt));
      end
      if (busy_out) begin
        if (!in_frame) begin
          in_frame = 1;
          nbits = 0; got = '0; start_cyc = cyc; done_at = -1; ndone = 0;
        end
        if (nbits < 16) got[nbits] = tx_out;
        if (done_out) begin ndone++; done_at = nbits; end
        nbits++;
      end else begin
        chk("idle_tx", int'(tx_out), 1);
        chk("idle_done", int'(done_out), 0);
        if (in_frame) begin
          in_frame = 0;
          if (frame_q.size() == 0) chk("unexpected_frame", 1, 0);
          else begin
            e = frame_q.pop_front();
            mask = 16'((32'd1 << e.len) - 1);
            chk("frame_len", nbits, e.len);
            chk("frame_bits", int'(got & mask), int'(e.bits & mask));
            chk("frame_start", start_cyc, e.start);
            chk("done_pos", (ndone == 1) ? done_at : -1, e.len - 1);
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic en, input logic ty);
    int n = 0;
    @(negedge clk);
    while (cool != 0 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("send_wait_timeout", n, 0);
    data_valid_in = 1'b1; data_in = d; par_en_in = en; par_type_in = ty;
    @(negedge clk);
    // flip everything mid-frame; the frame in flight must not notice
    data_valid_in = 1'b0; data_in = ~d; par_en_in = ~en; par_type_in = ~ty;
  endtask

  logic [W-1:0] dir_d  [6] = '{8'hA5, 8'hA5, 8'hA5, 8'h07, 8'h00, 8'hFF};
  logic         dir_en [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic         dir_ty [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    for (int i = 0; i < 6; i++) send(dir_d[i], dir_en[i], dir_ty[i]);

    // requests held continuously: back-to-back frames one idle cycle apart
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      data_valid_in = 1'b1;
      data_in = (cool == 0) ? 8'h3C : W'($urandom);
      par_en_in = c[4];
      par_type_in = $urandom_range(0, 1);
    end
    data_valid_in = 1'b0;

    // reset during data bit 4 of a frame
    send(8'h5A, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    frame_q.delete();
    strobe_q.delete();
    #1;
    chk("midreset_tx", int'(tx_out), 1);
    chk("midreset_busy", int'(busy_out), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    send(8'hC3, 1'b1, 1'b1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      data_valid_in = ($urandom_range(0, 2) == 0);
      data_in = W'($urandom);
      par_en_in = $urandom_range(0, 1);
      par_type_in = $urandom_range(0, 1);
    end
    data_valid_in = 1'b0;

    n = 0;
    while ((frame_q.size() != 0 || in_frame) && n < 100) begin @(negedge clk); n++; end
    chk("drain_frames", frame_q.size(), 0);
    chk("drain_strobes", strobe_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
